line_buf_reader: RTL and testbench
==================================

LINE_BUF_READER -- requirements
Module: line_buf_reader

Interface
REQ-001 Parameter dataWidth, default 8, pixel/word width; SHALL equal the attached RAM data width.
REQ-002 Parameter arrayWidth, default 4, RAM address width; size = 2**arrayWidth words.
REQ-003 clk  in  1  single clock; all state on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to stream one line.
REQ-006 baseAddr  in  arrayWidth  first RAM address of the line, sampled with start.
REQ-007 lineLen  in  arrayWidth+1  words to read (0..size), sampled with start.
REQ-008 busy  out  1  high while a line is in progress.
REQ-009 done  out  1  one-cycle pulse at line completion.
REQ-010 ramReadEnable  out  1  RAM read strobe.
REQ-011 ramReadAddr  out  arrayWidth  RAM read address.
REQ-012 ramReadData  in  dataWidth  RAM read data, valid the cycle after ramReadEnable.
REQ-013 outValid  out  1; outReady  in  1; outData  out  dataWidth: valid/ready stream.
REQ-014 outEol  out  1  high with the last word of a line (LINE_BUF_READER_EOL_EN only).

Function
REQ-015 FSM states: IDLE, READ (issuing), DRAIN (all issued, words outstanding).
REQ-016 IDLE->READ when start high and lineLen!=0; start while busy SHALL be ignored.
REQ-017 start with lineLen==0 SHALL pulse done the next cycle, issue no reads, stay IDLE.
REQ-018 Read k SHALL use address (baseAddr+k) mod size; wrap past size-1 to 0.
REQ-019 Reads issued strictly in order, exactly lineLen reads per line, no gaps forced.
REQ-020 Returned words SHALL enter a 2-entry FIFO the cycle after the read; outData is FIFO head.
REQ-021 Read issued only when FIFO occupancy + in-flight reads - same-cycle pop < 2; no overflow ever.
REQ-022 Latency: start in cycle 0 -> ramReadEnable cycle 1 (addr baseAddr) -> outValid cycle 3.
REQ-023 With outReady held high, one word per cycle sustained after the initial latency.
REQ-024 outValid/outData SHALL hold stable while outValid && !outReady.
REQ-025 READ->DRAIN after the last read issues; DRAIN->IDLE on the last word's handshake.
REQ-026 done SHALL pulse the cycle after the last handshake; busy falls in that same cycle.
REQ-027 busy high from the cycle after start accepted until done.
REQ-028 A new start in the cycle done is high SHALL be accepted.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, FIFO empty, in-flight count 0.
REQ-030 Reset values: busy, done, ramReadEnable, outValid, outEol = 0; ramReadAddr, outData = 0.
REQ-031 Reset mid-line SHALL discard the line; the data returned for an in-flight read is dropped.

Configuration
REQ-032 Macro LINE_BUF_READER_EOL_EN defined: outEol port present, stored per FIFO entry, high only with last word.
REQ-033 Macro undefined: outEol port absent; all other behaviour identical.

Structure
REQ-034 Shared package isp_buf_pkg holds the FSM state enum and FIFO depth constant (2).
REQ-035 One sub-module, skid_fifo2 (2-entry valid/ready FIFO), natural; address/FSM logic in top.

Verification
REQ-036 baseAddr=3, lineLen=5, outReady=1, RAM[i]=i+16 -> outData 19,20,21,22,23 in cycles 3..7, done cycle 8.
REQ-037 arrayWidth=4, baseAddr=14, lineLen=4 -> addresses 14,15,0,1 in order; outEol with last word only.
REQ-038 lineLen=6, outReady toggles 1,0,0,1 repeating -> all 6 words in order, none lost/duplicated, data stable while stalled.
REQ-039 lineLen=0 -> no ramReadEnable, done in cycle 1, busy never high; lineLen=16 -> all 16 addresses read once.
REQ-040 rst_n low during cycle 4 of an 8-word line -> outputs zero, FIFO empty; new start after release streams correct fresh line.

Source files
------------

// File: rtl/isp_buf_pkg.sv
// Shared types and constants for the line buffer reader and its output FIFO.
// Holds the reader FSM state encoding and the FIFO depth.
package isp_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/line_buf_reader_if.sv
// Valid/ready output stream of the line buffer reader.
// outEol exists only when LINE_BUF_READER_EOL_EN is defined.
interface line_buf_reader_if #(
  parameter int dataWidth = 8
) ();

  logic                 outValid;
  logic                 outReady;
  logic [dataWidth-1:0] outData;
`ifdef LINE_BUF_READER_EOL_EN
  logic                 outEol;

  modport master (
    output outValid,
    output outData,
    output outEol,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  outData,
    input  outEol,
    output outReady
  );
`else
  modport master (
    output outValid,
    output outData,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  outData,
    output outReady
  );
`endif

endinterface

// File: rtl/skid_fifo2.sv
// Two-entry valid/ready FIFO; head is presented directly on the output.
// The caller guarantees it never pushes into a full FIFO.
module skid_fifo2
  import isp_buf_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;
  logic         take;

  assign valid = (cnt != 2'd0);
  assign head  = mem[rp];
  assign count = cnt;
  assign take  = pop && valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= ~wp;
      end
      if (take) begin
        rp <= ~rp;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, take};
    end
  end

endmodule

// File: rtl/line_buf_reader.sv
// Streams one line of words out of a synchronous RAM onto a valid/ready port.
// Define LINE_BUF_READER_EOL_EN to add outEol on the last word of each line.
module line_buf_reader
  import isp_buf_pkg::*;
#(
  parameter int dataWidth  = 8,
  parameter int arrayWidth = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [arrayWidth-1:0] baseAddr,
  input  logic [arrayWidth:0]   lineLen,
  output logic                  busy,
  output logic                  done,
  output logic                  ramReadEnable,
  output logic [arrayWidth-1:0] ramReadAddr,
  input  logic [dataWidth-1:0]  ramReadData,
  line_buf_reader_if.master     stream
);

  localparam logic [arrayWidth:0] ONE = (arrayWidth+1)'(1);

`ifdef LINE_BUF_READER_EOL_EN
  localparam int EW = dataWidth + 1;
`else
  localparam int EW = dataWidth;
`endif

  state_t                state;
  state_t                state_nx;
  logic [arrayWidth-1:0] addr_q;
  logic [arrayWidth:0]   issue_left;
  logic [arrayWidth:0]   out_left;
  logic                  pend;
  logic                  done_q;
  logic                  start_ok;
  logic                  zero_ok;
  logic                  issue;
  logic                  pop;
  logic                  last_pop;
  logic                  last_issue;
  logic [1:0]            occ;
  logic [2:0]            load;
  logic [EW-1:0]         push_data;
  logic [EW-1:0]         head;
  logic                  fifo_valid;

  assign start_ok   = (state == IDLE) && start && (lineLen != '0);
  assign zero_ok    = (state == IDLE) && start && (lineLen == '0);
  assign pop        = fifo_valid && stream.outReady;
  assign last_pop   = pop && (out_left == ONE);
  assign last_issue = issue && (issue_left == ONE);

  // Words already held plus the one arriving now must leave room for this read.
  assign load  = {1'b0, occ} + {2'b0, pend};
  assign issue = (state == READ) && (load < (3'd2 + {2'b0, pop}));

  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign ramReadEnable = issue;
  assign ramReadAddr   = addr_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_ok) state_nx = READ;
      READ:    if (last_issue) state_nx = DRAIN;
      DRAIN:   if (last_pop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      issue_left <= '0;
      out_left   <= '0;
      pend       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nx;
      pend   <= issue;
      done_q <= zero_ok || ((state == DRAIN) && last_pop);
      if (start_ok) begin
        addr_q     <= baseAddr;
        issue_left <= lineLen;
        out_left   <= lineLen;
      end else begin
        if (issue) begin
          addr_q     <= addr_q + 1'b1;
          issue_left <= issue_left - ONE;
        end
        if (pop) begin
          out_left <= out_left - ONE;
        end
      end
    end
  end

`ifdef LINE_BUF_READER_EOL_EN
  logic pend_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_last <= 1'b0;
    end else begin
      pend_last <= last_issue;
    end
  end

  assign push_data     = {pend_last, ramReadData};
  assign stream.outEol = head[dataWidth];
`else
  assign push_data = ramReadData;
`endif

  assign stream.outData  = head[dataWidth-1:0];
  assign stream.outValid = fifo_valid;

  skid_fifo2 #(
    .W (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend),
    .push_data (push_data),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (head),
    .count     (occ)
  );

endmodule

// File: tb/tb_line_buf_reader.sv
// Directed bench for line_buf_reader with a one-cycle-latency RAM model.
// outEol is checked only when LINE_BUF_READER_EOL_EN is defined.
module tb_line_buf_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] baseAddr;
  logic [4:0] lineLen;
  logic       busy;
  logic       done;
  logic       ramReadEnable;
  logic [3:0] ramReadAddr;
  logic [7:0] ramReadData = 8'd0;
  logic [7:0] ram [16];

  int n_tests = 0;
  int n_fail  = 0;

  line_buf_reader_if #(.dataWidth(8)) bus ();

  line_buf_reader #(
    .dataWidth  (8),
    .arrayWidth (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .baseAddr      (baseAddr),
    .lineLen       (lineLen),
    .busy          (busy),
    .done          (done),
    .ramReadEnable (ramReadEnable),
    .ramReadAddr   (ramReadAddr),
    .ramReadData   (ramReadData),
    .stream        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramReadEnable) ramReadData <= ram[ramReadAddr];
  end

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if ({busy, done, ramReadEnable, bus.outValid} !== 4'b0000
          || ramReadAddr !== 4'd0 || bus.outData !== 8'd0)
        $display("FAIL reset_state phase=%0d ctl=%b addr=%0d data=%0d required ctl=0000 addr=0 data=0",
                 k, {busy, done, ramReadEnable, bus.outValid}, ramReadAddr, bus.outData);
`ifdef LINE_BUF_READER_EOL_EN
      n_tests++;
      if (bus.outEol !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_eol got=%b required=0", bus.outEol);
      end
`endif
      if ({busy, done, ramReadEnable, bus.outValid} !== 4'b0000
          || ramReadAddr !== 4'd0 || bus.outData !== 8'd0) n_fail++;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
  endtask

  task automatic test_basic();
    logic [3:0] exp_ctl;
    baseAddr = 4'd3; lineLen = 5'd5; bus.outReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      start = (c == 0);
      @(negedge clk);
      exp_ctl = {c >= 1 && c <= 7, c == 8, c >= 1 && c <= 5, c >= 3 && c <= 7};
      n_tests++;
      if ({busy, done, ramReadEnable, bus.outValid} !== exp_ctl) begin
        n_fail++;
        $display("FAIL basic_ctl cycle=%0d got=%b required=%b", c,
                 {busy, done, ramReadEnable, bus.outValid}, exp_ctl);
      end
      if (c >= 1 && c <= 5) begin
        n_tests++;
        if (ramReadAddr !== 4'(c + 2)) begin
          n_fail++;
          $display("FAIL basic_addr cycle=%0d got=%0d required=%0d", c, ramReadAddr, c + 2);
        end
      end
      if (c >= 3 && c <= 7) begin
        n_tests++;
        if (bus.outData !== 8'(c + 16)) begin
          n_fail++;
          $display("FAIL basic_data cycle=%0d got=%0d required=%0d", c, bus.outData, c + 16);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_addr [4];
    logic [7:0] exp_data [4];
    exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
    exp_data = '{8'd30, 8'd31, 8'd16, 8'd17};
    baseAddr = 4'd14; lineLen = 5'd4; bus.outReady = 1'b1;
    for (int c = 0; c < 9; c++) begin
      start = (c == 0);
      @(negedge clk);
      n_tests++;
      if ({ramReadEnable, bus.outValid, done} !== {c >= 1 && c <= 4, c >= 3 && c <= 6, c == 7}) begin
        n_fail++;
        $display("FAIL wrap_ctl cycle=%0d got=%b", c, {ramReadEnable, bus.outValid, done});
      end
      if (c >= 1 && c <= 4) begin
        n_tests++;
        if (ramReadAddr !== exp_addr[c-1]) begin
          n_fail++;
          $display("FAIL wrap_addr cycle=%0d got=%0d required=%0d", c, ramReadAddr, exp_addr[c-1]);
        end
      end
      if (c >= 3 && c <= 6) begin
        n_tests++;
        if (bus.outData !== exp_data[c-3]) begin
          n_fail++;
          $display("FAIL wrap_data cycle=%0d got=%0d required=%0d", c, bus.outData, exp_data[c-3]);
        end
`ifdef LINE_BUF_READER_EOL_EN
        n_tests++;
        if (bus.outEol !== (c == 6)) begin
          n_fail++;
          $display("FAIL wrap_eol cycle=%0d got=%b required=%b", c, bus.outEol, c == 6);
        end
`endif
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_stall();
    logic [7:0] got [$];
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'd0;
    bit         seen_done = 1'b0;
    baseAddr = 4'd0; lineLen = 5'd6;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      start = (c == 0);
      bus.outReady = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
      if (pv && !pr) begin
        n_tests++;
        if (bus.outValid !== 1'b1 || bus.outData !== pd) begin
          n_fail++;
          $display("FAIL stall_hold cycle=%0d valid=%b data=%0d required valid=1 data=%0d",
                   c, bus.outValid, bus.outData, pd);
        end
      end
      if (bus.outValid && bus.outReady) got.push_back(bus.outData);
      if (done) seen_done = 1'b1;
      pv = bus.outValid; pr = bus.outReady; pd = bus.outData;
      @(posedge clk); #1;
    end
    start = 1'b0; bus.outReady = 1'b1;
    n_tests++;
    if (!seen_done || got.size() != 6) begin
      n_fail++;
      $display("FAIL stall_count done=%b words=%0d required done=1 words=6", seen_done, got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_tests++;
      if (got[i] !== 8'(16 + i)) begin
        n_fail++;
        $display("FAIL stall_order idx=%0d got=%0d required=%0d", i, got[i], 16 + i);
      end
    end
  endtask

  task automatic test_len_limits();
    logic [3:0] addrs [$];
    logic [7:0] words [$];
    bit         seen_done = 1'b0;
    baseAddr = 4'd9; lineLen = 5'd0; bus.outReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      start = (c == 0);
      @(negedge clk);
      n_tests++;
      if ({busy, ramReadEnable, done} !== {1'b0, 1'b0, c == 1}) begin
        n_fail++;
        $display("FAIL zero_len cycle=%0d busy/ren/done=%b required=00%b", c,
                 {busy, ramReadEnable, done}, c == 1);
      end
      @(posedge clk); #1;
    end
    baseAddr = 4'd5; lineLen = 5'd16;
    for (int c = 0; c < 50 && !seen_done; c++) begin
      start = (c == 0);
      @(negedge clk);
      if (ramReadEnable) addrs.push_back(ramReadAddr);
      if (bus.outValid && bus.outReady) words.push_back(bus.outData);
      if (done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_tests++;
    if (!seen_done || addrs.size() != 16 || words.size() != 16) begin
      n_fail++;
      $display("FAIL full_len_count done=%b reads=%0d words=%0d required 1/16/16",
               seen_done, addrs.size(), words.size());
    end
    for (int k = 0; k < 16 && k < addrs.size() && k < words.size(); k++) begin
      n_tests++;
      if (addrs[k] !== 4'(5 + k) || words[k] !== 8'(16 + ((5 + k) % 16))) begin
        n_fail++;
        $display("FAIL full_len_seq k=%0d addr=%0d data=%0d required addr=%0d data=%0d",
                 k, addrs[k], words[k], (5 + k) % 16, 16 + ((5 + k) % 16));
      end
    end
  endtask

  task automatic test_back_to_back();
    int nreads = 0;
    bus.outReady = 1'b1;
    for (int c = 0; c < 11; c++) begin
      start    = (c == 0) || (c == 2) || (c == 5);
      baseAddr = (c == 5) ? 4'd7 : ((c == 2) ? 4'd9 : 4'd0);
      lineLen  = (c == 5) ? 5'd1 : ((c == 2) ? 5'd3 : 5'd2);
      @(negedge clk);
      if (ramReadEnable) nreads++;
      if (c == 5 || c == 9) begin
        n_tests++;
        if (done !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_done cycle=%0d got=%b required=1", c, done);
        end
      end
      if (c == 6) begin
        n_tests++;
        if ({busy, ramReadEnable} !== 2'b11 || ramReadAddr !== 4'd7) begin
          n_fail++;
          $display("FAIL b2b_restart busy/ren=%b addr=%0d required 11 addr=7",
                   {busy, ramReadEnable}, ramReadAddr);
        end
      end
      if (c == 8) begin
        n_tests++;
        if (bus.outValid !== 1'b1 || bus.outData !== 8'd23) begin
          n_fail++;
          $display("FAIL b2b_data valid=%b data=%0d required valid=1 data=23",
                   bus.outValid, bus.outData);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_tests++;
    if (nreads != 3) begin
      n_fail++;
      $display("FAIL b2b_ignore_busy reads=%0d required=3", nreads);
    end
  endtask

  task automatic test_reset_mid();
    baseAddr = 4'd0; lineLen = 5'd8; bus.outReady = 1'b1;
    for (int c = 0; c < 8; c++) begin
      start = (c == 0);
      if (c == 4) rst_n = 1'b0;
      if (c == 5) rst_n = 1'b1;
      @(negedge clk);
      if (c == 4) begin
        n_tests++;
        if ({busy, done, ramReadEnable, bus.outValid} !== 4'b0000
            || ramReadAddr !== 4'd0 || bus.outData !== 8'd0) begin
          n_fail++;
          $display("FAIL midreset_zero ctl=%b addr=%0d data=%0d required all zero",
                   {busy, done, ramReadEnable, bus.outValid}, ramReadAddr, bus.outData);
        end
      end
      if (c >= 5) begin
        n_tests++;
        if ({busy, ramReadEnable, bus.outValid} !== 3'b000) begin
          n_fail++;
          $display("FAIL midreset_drop cycle=%0d busy/ren/valid=%b required=000", c,
                   {busy, ramReadEnable, bus.outValid});
        end
      end
      @(posedge clk); #1;
    end
    baseAddr = 4'd8; lineLen = 5'd3;
    for (int c = 0; c < 8; c++) begin
      start = (c == 0);
      @(negedge clk);
      n_tests++;
      if ({bus.outValid, done} !== {c >= 3 && c <= 5, c == 6}) begin
        n_fail++;
        $display("FAIL fresh_ctl cycle=%0d valid/done=%b", c, {bus.outValid, done});
      end
      if (c >= 3 && c <= 5) begin
        n_tests++;
        if (bus.outData !== 8'(21 + c)) begin
          n_fail++;
          $display("FAIL fresh_data cycle=%0d got=%0d required=%0d", c, bus.outData, 21 + c);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'(i + 16);
    rst_n = 1'b0; start = 1'b0; baseAddr = 4'd0; lineLen = 5'd0;
    bus.outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_len_limits();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
